// File: rtl/freq_ctrl_sync.sv
// Frequency control word conditioner: synchronises the ADC SPI strobe, clamps
// the word and slew-limits the output per sample_tick. Optional macro FREQ_AVG_EN.
module freq_ctrl_sync #(
  parameter logic [15:0] FREQ_MIN   = 16'd20,
  parameter logic [15:0] FREQ_MAX   = 16'd20000,
  parameter logic [15:0] FREQ_RESET = 16'd2000,
  parameter logic [15:0] SLEW_STEP  = 16'd64
) (
  input  logic        fpga_clock,
  input  logic        reset,
  input  logic [15:0] adc_data,
  input  logic        adc_data_received,
  input  logic        sample_tick,
  output logic [15:0] frequency,
  output logic        freq_update,
  output logic [15:0] target,
  output logic        overrun_err
);

  // state     | meaning
  // IDLE      | frequency == target, nothing to do on a tick
  // SLEW_UP   | frequency < target, step up on the next tick
  // SLEW_DOWN | frequency > target, step down on the next tick
  typedef enum logic [1:0] {IDLE, SLEW_UP, SLEW_DOWN} state_t;

  state_t      state_q, state_d;
  logic [2:0]  sync_q, sync_d;
  logic [15:0] raw_q, raw_d;
  logic        raw_vld_q, raw_vld_d;
  logic [15:0] clamped_q, clamped_d;
  logic        clamped_vld_q, clamped_vld_d;
  logic [15:0] target_q, target_d;
  logic        pending_q, pending_d;
  logic        overrun_q, overrun_d;
  logic [15:0] frequency_q, frequency_d;
  logic        freq_update_q, freq_update_d;
  logic        strobe_edge, tgt_wr;
  logic [15:0] tgt_val, diff_up, diff_dn;

  assign sync_d      = {sync_q[1:0], adc_data_received};
  assign strobe_edge = sync_q[1] & ~sync_q[2];

  always_comb begin
    raw_d         = raw_q;
    raw_vld_d     = strobe_edge;
    clamped_d     = clamped_q;
    clamped_vld_d = raw_vld_q;
    if (strobe_edge) raw_d = adc_data;
    if (raw_vld_q) begin
      if (raw_q < FREQ_MIN)      clamped_d = FREQ_MIN;
      else if (raw_q > FREQ_MAX) clamped_d = FREQ_MAX;
      else                       clamped_d = raw_q;
    end
  end

`ifdef FREQ_AVG_EN
  logic [15:0] hist_q [4];
  logic [15:0] hist_d [4];
  logic        hist_vld_q;
  logic [17:0] hist_sum;

  always_comb begin
    hist_d = hist_q;
    if (clamped_vld_q) hist_d = '{clamped_q, hist_q[0], hist_q[1], hist_q[2]};
    hist_sum = {2'b00, hist_q[0]} + {2'b00, hist_q[1]} + {2'b00, hist_q[2]} + {2'b00, hist_q[3]};
  end

  always_ff @(posedge fpga_clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) hist_q[i] <= FREQ_RESET;
      hist_vld_q <= 1'b0;
    end else begin
      hist_q     <= hist_d;
      hist_vld_q <= clamped_vld_q;
    end
  end

  assign tgt_wr  = hist_vld_q;
  assign tgt_val = hist_sum[17:2];
`else
  assign tgt_wr  = clamped_vld_q;
  assign tgt_val = clamped_q;
`endif

  // A tick coinciding with a write clears the old pending and the write sets it again.
  always_comb begin
    target_d  = tgt_wr ? tgt_val : target_q;
    pending_d = tgt_wr ? 1'b1 : (sample_tick ? 1'b0 : pending_q);
    overrun_d = overrun_q | (tgt_wr & pending_q & ~sample_tick);
  end

  always_comb begin
    diff_up       = target_q - frequency_q;
    diff_dn       = frequency_q - target_q;
    frequency_d   = frequency_q;
    freq_update_d = 1'b0;
    if (sample_tick) begin
      case (state_q)
        SLEW_UP: begin
          frequency_d   = frequency_q + ((diff_up > SLEW_STEP) ? SLEW_STEP : diff_up);
          freq_update_d = 1'b1;
        end
        SLEW_DOWN: begin
          frequency_d   = frequency_q - ((diff_dn > SLEW_STEP) ? SLEW_STEP : diff_dn);
          freq_update_d = 1'b1;
        end
        default: ;
      endcase
    end
    // State always tracks the registered compare of the values about to be held.
    if (frequency_d < target_d)      state_d = SLEW_UP;
    else if (frequency_d > target_d) state_d = SLEW_DOWN;
    else                             state_d = IDLE;
  end

  always_ff @(posedge fpga_clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      sync_q        <= 3'b000;
      raw_q         <= '0;
      raw_vld_q     <= 1'b0;
      clamped_q     <= '0;
      clamped_vld_q <= 1'b0;
      target_q      <= FREQ_RESET;
      pending_q     <= 1'b0;
      overrun_q     <= 1'b0;
      frequency_q   <= FREQ_RESET;
      freq_update_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sync_q        <= sync_d;
      raw_q         <= raw_d;
      raw_vld_q     <= raw_vld_d;
      clamped_q     <= clamped_d;
      clamped_vld_q <= clamped_vld_d;
      target_q      <= target_d;
      pending_q     <= pending_d;
      overrun_q     <= overrun_d;
      frequency_q   <= frequency_d;
      freq_update_q <= freq_update_d;
    end
  end

  assign frequency   = frequency_q;
  assign freq_update = freq_update_q;
  assign target      = target_q;
  assign overrun_err = overrun_q;

endmodule

// File: tb/tb_freq_ctrl_sync.sv
// Self-checking bench for freq_ctrl_sync: reference model plus a queue of
// expected frequency steps popped on every freq_update pulse.
module tb_freq_ctrl_sync;

  localparam logic [15:0] FMIN  = 16'd20;
  localparam logic [15:0] FMAX  = 16'd20000;
  localparam logic [15:0] FRST  = 16'd2000;
  localparam logic [15:0] STEP  = 16'd64;
`ifdef FREQ_AVG_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 5;
`endif

  logic        fpga_clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] adc_data = '0;
  logic        adc_data_received = 1'b0;
  logic        sample_tick = 1'b0;
  logic [15:0] frequency, target;
  logic        freq_update, overrun_err;

  freq_ctrl_sync dut (
    .fpga_clock       (fpga_clock),
    .reset            (reset),
    .adc_data         (adc_data),
    .adc_data_received(adc_data_received),
    .sample_tick      (sample_tick),
    .frequency        (frequency),
    .freq_update      (freq_update),
    .target           (target),
    .overrun_err      (overrun_err)
  );

  always #5 fpga_clock = ~fpga_clock;

  int n_checks = 0;
  int n_fail   = 0;
  int upd_seen = 0;
  int upd_exp  = 0;

  logic [15:0] exp_q[$];
  logic [15:0] freq_m, tgt_m;
  logic [15:0] hist_m [4];
  bit          pending_m, ovr_m;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] clamp(input logic [15:0] v);
    if (v < FMIN) return FMIN;
    if (v > FMAX) return FMAX;
    return v;
  endfunction

  function automatic logic [15:0] next_freq(input logic [15:0] f, input logic [15:0] t);
    if (f < t) return (t - f > STEP) ? f + STEP : t;
    if (f > t) return (f - t > STEP) ? f - STEP : t;
    return f;
  endfunction

  function automatic void model_reset();
    freq_m = FRST;
    tgt_m  = FRST;
    for (int i = 0; i < 4; i++) hist_m[i] = FRST;
    pending_m = 0;
    ovr_m     = 0;
  endfunction

  function automatic void model_write(input logic [15:0] v);
    logic [17:0] sum;
    hist_m[3] = hist_m[2];
    hist_m[2] = hist_m[1];
    hist_m[1] = hist_m[0];
    hist_m[0] = clamp(v);
    sum = 18'(hist_m[0]) + 18'(hist_m[1]) + 18'(hist_m[2]) + 18'(hist_m[3]);
`ifdef FREQ_AVG_EN
    tgt_m = sum[17:2];
`else
    tgt_m = clamp(v);
`endif
  endfunction

  // Scoreboard: every freq_update pulse must match the next queued step.
  always @(negedge fpga_clock) begin
    if (!reset && freq_update) begin
      upd_seen++;
      if (exp_q.size() == 0) check("freq_update_spurious", 1, 0);
      else check("freq_step", frequency, exp_q.pop_front());
    end
  end

  task automatic tick();
    logic [15:0] nf;
    bit upd;
    nf  = next_freq(freq_m, tgt_m);
    upd = (nf != freq_m);
    if (upd) begin exp_q.push_back(nf); upd_exp++; end
    freq_m    = nf;
    pending_m = 0;
    sample_tick = 1'b1;
    @(negedge fpga_clock);
    sample_tick = 1'b0;
    check("freq_tick", frequency, freq_m);
    check("freq_update", freq_update, upd);
  endtask

  task automatic slew_to_target();
    int n = 0;
    while (freq_m != tgt_m && n < 400) begin tick(); n++; end
    check("slew_bound", (n < 400), 1);
    tick();
    tick();
  endtask

  // Strobe starts at a negedge; optional tick lands on the target-write edge.
  task automatic strobe(input logic [15:0] v, input bit tick_at_wr);
    logic [15:0] nf;
    bit upd = 0;
    bit was_pending;
    adc_data = v;
    adc_data_received = 1'b1;
    for (int i = 1; i <= LAT + 3; i++) begin
      @(negedge fpga_clock);
      if (i == 3) adc_data_received = 1'b0;
      if (tick_at_wr && i == LAT - 1) begin
        sample_tick = 1'b1;
        nf  = next_freq(freq_m, tgt_m);
        upd = (nf != freq_m);
        if (upd) begin exp_q.push_back(nf); upd_exp++; end
        freq_m = nf;
      end
      if (tick_at_wr && i == LAT) begin
        sample_tick = 1'b0;
        check("sim_tick_freq", frequency, freq_m);
        check("sim_tick_update", freq_update, upd);
      end
    end
    was_pending = pending_m;
    if (was_pending && !tick_at_wr) ovr_m = 1;
    pending_m = 1;
    model_write(v);
    check("target", target, tgt_m);
    check("overrun", overrun_err, ovr_m);
  endtask

  task automatic do_reset();
    @(negedge fpga_clock);
    reset = 1'b1;
    sample_tick = 1'b0;
    adc_data_received = 1'b0;
    #1;
    check("rst_frequency", frequency, FRST);
    check("rst_target", target, FRST);
    check("rst_freq_update", freq_update, 0);
    check("rst_overrun", overrun_err, 0);
    check("rst_queue_empty", exp_q.size(), 0);
    exp_q.delete();
    model_reset();
    @(negedge fpga_clock);
    reset = 1'b0;
    @(negedge fpga_clock);
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge fpga_clock);
    check("init_frequency", frequency, FRST);
    check("init_target", target, FRST);
    check("init_freq_update", freq_update, 0);
    check("init_overrun", overrun_err, 0);
    reset = 1'b0;
    @(negedge fpga_clock);

    // Basic step-up to 2256 and settle.
    strobe(16'd2256, 0);
    for (int i = 0; i < 6; i++) tick();
    @(negedge fpga_clock);
`ifndef FREQ_AVG_EN
    check("basic_final", frequency, 16'd2256);
    check("basic_updates", upd_seen, 4);
`endif
    check("basic_updates_model", upd_seen, upd_exp);

    // Clamp boundaries.
    strobe(16'd5, 0);
`ifndef FREQ_AVG_EN
    check("clamp_low", target, 16'd20);
`endif
    slew_to_target();
    check("end_low", frequency, tgt_m);
    strobe(16'hFFFF, 0);
`ifndef FREQ_AVG_EN
    check("clamp_high", target, 16'd20000);
`endif
    slew_to_target();
    check("end_high", frequency, tgt_m);

    // Overrun: two captures with no tick between.
    strobe(16'd3000, 0);
    strobe(16'd4000, 0);
`ifndef FREQ_AVG_EN
    check("overrun_target", target, 16'd4000);
`endif
    check("overrun_set", overrun_err, 1);
    slew_to_target();
    check("overrun_sticky", overrun_err, 1);
    do_reset();

    // Capture landing on the same edge as a tick.
    strobe(16'd2500, 1);
    check("sim_no_overrun", overrun_err, 0);
    tick();
    check("sim_next_tick", frequency, 16'd2064);
    slew_to_target();
    check("sim_no_overrun_end", overrun_err, 0);
    do_reset();

    // Reset in the middle of a slew.
    strobe(16'd10000, 0);
    for (int n = 0; n < 50 && freq_m != 16'd2640; n++) tick();
    check("midslew_reached", frequency, 16'd2640);
    do_reset();

    // Four equal captures with ticks between.
    for (int k = 0; k < 4; k++) begin
      strobe(16'd1000, 0);
`ifdef FREQ_AVG_EN
      check("avg_target", target, 16'(1750 - 250 * k));
`else
      check("latest_target", target, 16'd1000);
`endif
      tick();
    end
    slew_to_target();
    @(negedge fpga_clock);
    check("final_queue_empty", exp_q.size(), 0);
    check("final_updates", upd_seen, upd_exp);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/freq_ctrl_sync.md
Name: freq_ctrl_sync

Overview:
Conditions the oscillator frequency control word between the ADC SPI receiver and the phase-accumulator/sine-LUT sample engine. It takes the receiver's 16-bit word and its completion strobe from the SPI clock domain and resynchronises the strobe into fpga_clock. Each captured word is clamped to a legal range, and the frequency output is slew-limited one step per sample tick. The sample engine reads frequency as a stable, glitch-free fpga_clock-domain value.

Parameters:
FREQ_MIN, 16'd20, lowest legal frequency word
FREQ_MAX, 16'd20000, highest legal frequency word; must be < SAMPLERATE (44000)
FREQ_RESET, 16'd2000, frequency/target value after reset; FREQ_MIN <= FREQ_RESET <= FREQ_MAX
SLEW_STEP, 16'd64, maximum change of frequency per sample_tick; >= 1

Ports:
fpga_clock  in  1  system clock, 84 MHz
reset  in  1  asynchronous, active-high
adc_data  in  16  ADC word; stable >= 6 fpga_clock cycles after adc_data_received rises
adc_data_received  in  1  asynchronous completion strobe, high >= 2 fpga_clock cycles
sample_tick  in  1  one-cycle pulse per audio sample, from the sample timer
frequency  out  16  slew-limited frequency word to the phase accumulator
freq_update  out  1  one-cycle pulse: frequency changed this cycle
target  out  16  current clamped (and averaged) target, for debug
overrun_err  out  1  sticky: second capture arrived before any sample_tick consumed the first

Behaviour:
- Reset is an already-decided interface fact: reset is asynchronous, active-high; the clock is fpga_clock. On reset: frequency = target = FREQ_RESET; freq_update = 0; overrun_err = 0; synchroniser flops = 0; pending = 0; state = IDLE. Reset mid-slew aborts immediately.
- Synchroniser: 3-flop chain on adc_data_received. A rising edge is detected on flop 2 versus flop 3. In the detect cycle, adc_data is captured into raw (flop timing is fixed, no data handshake).
- Clamp stage (registered, +1 cycle): clamped = (raw < FREQ_MIN) ? FREQ_MIN : (raw > FREQ_MAX) ? FREQ_MAX : raw.
- Target stage (+1 cycle): target <= clamped (or average, see Optional Feature); pending <= 1.
- Latency: adc_data_received rise to target updated is 5–6 fpga_clock cycles. No effect on frequency before the next sample_tick.
- Overrun: if target is written while pending = 1, set overrun_err (sticky until reset). The newest word wins.
- sample_tick clears pending.
- FSM, evaluated only on sample_tick cycles:
  - IDLE: frequency == target; no change.
  - SLEW_UP: frequency < target; frequency += min(SLEW_STEP, target - frequency).
  - SLEW_DOWN: frequency > target; frequency -= min(SLEW_STEP, frequency - target).
  - State is recomputed every cycle from the compare. A target change mid-slew may reverse direction at the next tick.
- freq_update is asserted in the same cycle as the frequency register write; it is never asserted in IDLE.
- Arithmetic: 16-bit unsigned. Operands are always inside [FREQ_MIN, FREQ_MAX], so subtraction cannot underflow. Frequency never overshoots target.
- Simultaneous events:
  - sample_tick in the same cycle as a target write: the slew uses the old target.
  - That same tick also clears pending, and the new write sets pending, so the net result is pending = 1. No overrun is raised.
- adc_data_received held high indefinitely: exactly one capture per rising edge.

Optional Feature:
- Macro: FREQ_AVG_EN.
- Defined: target = mean of the last 4 clamped words. Computed as an 18-bit sum >> 2, truncating. The 4-entry history is a shift register, all entries FREQ_RESET at reset. Adds +1 cycle to the target stage.
- Undefined: target = latest clamped word; no history registers.

Test Plan:
- Reset, adc_data=2256 strobe, then sample_ticks -> frequency 2064, 2128, 2192, 2256, then constant. freq_update pulses exactly 4 times.
- adc_data=5 -> target=20; adc_data=65535 -> target=20000. Frequency slews down/up by 64 per tick and ends exactly on 20 / 20000.
- Two strobes (3000, then 4000) with no sample_tick between -> overrun_err=1, target=4000; overrun_err stays 1 until reset.
- Strobe landing in the same cycle as sample_tick (target 2500 from 2000) -> that tick leaves frequency 2000; next tick gives 2064; overrun_err stays 0.
- Assert reset while slewing 2000->10000 at frequency 2640 -> frequency=2000 and target=2000 immediately, freq_update=0.
- FREQ_AVG_EN defined, four strobes of 1000 with ticks between -> target 1750, 1500, 1250, 1000.
